// File: rtl/pwm_packet_transmitter_if.sv
// Handshake and differential line bundle for pwm_packet_transmitter.
// master = packet source side, slave = transmitter side.
interface pwm_packet_transmitter_if;
    logic       start;
    logic [3:0] data;
    logic       ready;
    logic       busy;
    logic       done;
    logic       TX_P;
    logic       TX_N;

    modport master (
        output start, data,
        input  ready, busy, done, TX_P, TX_N
    );

    modport slave (
        input  start, data,
        output ready, busy, done, TX_P, TX_N
    );
endinterface

// File: rtl/pwm_packet_transmitter.sv
// Serialises a 4-bit word as one differential PWM packet: SOP(00), symbols MSB first, EOP(11).
// Optional feature macro: PWM_TX_PARITY_EN appends an even-parity symbol after bit 0.
module pwm_packet_transmitter #(
    parameter int unsigned SOP_LEN   = 100,
    parameter int unsigned EOP_LEN   = 100,
    parameter int unsigned SYM_LEN   = 20,
    parameter int unsigned BIT0_HIGH = 5,
    parameter int unsigned BIT1_HIGH = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    pwm_packet_transmitter_if.slave   bus
);

    if (!(BIT0_HIGH > 0 && BIT0_HIGH < BIT1_HIGH && BIT1_HIGH < SYM_LEN) ||
        SOP_LEN < 1 || SOP_LEN > 255 || EOP_LEN < 1 || EOP_LEN > 255 ||
        SYM_LEN < 1 || SYM_LEN > 255) begin : g_param_check
        $error("pwm_packet_transmitter: illegal length parameters");
    end

`ifdef PWM_TX_PARITY_EN
    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = 3'd4;

    // Symbol index 4..1 carries data[3..0]; index 0 is the parity symbol.
    function automatic logic sym_bit(input logic [3:0] d, input logic [IDX_W-1:0] idx);
        if (idx == '0)
            return ^d;
        return d[2'(idx - 3'd1)];
    endfunction
`else
    localparam int unsigned IDX_W = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;

    function automatic logic sym_bit(input logic [3:0] d, input logic [IDX_W-1:0] idx);
        return d[idx];
    endfunction
`endif

    function automatic logic [7:0] high_len(input logic b);
        return b ? 8'(BIT1_HIGH) : 8'(BIT0_HIGH);
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOP,
        S_SYM_HI,
        S_SYM_LO,
        S_EOP
    } state_t;

    state_t           r_state, w_state;
    logic [7:0]       r_cnt,   w_cnt;
    logic [IDX_W-1:0] r_idx,   w_idx;
    logic [3:0]       r_data,  w_data;
    logic             r_tx_p,  w_tx_p;
    logic             r_tx_n,  w_tx_n;
    logic             r_done,  w_done;
    logic             w_cur_bit;
    logic             w_next_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx_p  <= 1'b1;
            r_tx_n  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_data  <= w_data;
            r_tx_p  <= w_tx_p;
            r_tx_n  <= w_tx_n;
            r_done  <= w_done;
        end
    end

    // Each phase loads its length-1 so the counter hits 0 on the phase's last cycle.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_data     = r_data;
        w_tx_p     = r_tx_p;
        w_tx_n     = r_tx_n;
        w_done     = 1'b0;
        w_cur_bit  = sym_bit(r_data, r_idx);
        w_next_bit = sym_bit(r_data, IDX_W'(r_idx - 1'b1));

        case (r_state)
            S_IDLE: begin
                w_tx_p = 1'b1;
                w_tx_n = 1'b1;
                if (bus.start) begin
                    w_state = S_SOP;
                    w_data  = bus.data;
                    w_idx   = LAST_IDX;
                    w_cnt   = 8'(SOP_LEN - 1);
                    w_tx_p  = 1'b0;
                    w_tx_n  = 1'b0;
                end
            end
            S_SOP: begin
                if (r_cnt == '0) begin
                    w_state = S_SYM_HI;
                    w_cnt   = high_len(w_cur_bit) - 8'd1;
                    w_tx_p  = 1'b1;
                    w_tx_n  = 1'b0;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            S_SYM_HI: begin
                if (r_cnt == '0) begin
                    w_state = S_SYM_LO;
                    w_cnt   = 8'(SYM_LEN) - high_len(w_cur_bit) - 8'd1;
                    w_tx_p  = 1'b0;
                    w_tx_n  = 1'b1;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            S_SYM_LO: begin
                if (r_cnt == '0) begin
                    if (r_idx == '0) begin
                        w_state = S_EOP;
                        w_cnt   = 8'(EOP_LEN - 1);
                        w_tx_p  = 1'b1;
                        w_tx_n  = 1'b1;
                    end else begin
                        w_state = S_SYM_HI;
                        w_idx   = IDX_W'(r_idx - 1'b1);
                        w_cnt   = high_len(w_next_bit) - 8'd1;
                        w_tx_p  = 1'b1;
                        w_tx_n  = 1'b0;
                    end
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            S_EOP: begin
                if (r_cnt == '0) begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx_p  = 1'b1;
                w_tx_n  = 1'b1;
            end
        endcase
    end

    assign bus.ready = (r_state == S_IDLE);
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = r_done;
    assign bus.TX_P  = r_tx_p;
    assign bus.TX_N  = r_tx_n;

endmodule
